// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side drives req/done; the slave side (the arbiter) drives the grant outputs.
interface rr_grant_arbiter_if #(
  parameter int N    = 8,
  parameter int LOGN = 3
);
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    grant;
  logic [LOGN-1:0] grant_idx;
  logic            grant_valid;
  logic            timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with grant lock; the owner holds the bus until done or it drops req.
// Optional hold-time watchdog is built only when RR_WATCHDOG_EN is defined.
module rr_grant_arbiter #(
  parameter int N        = 8,
  parameter int LOGN     = 3,
  parameter int MAX_HOLD = 255
) (
  input  logic                clk,
  input  logic                reset,
  rr_grant_arbiter_if.slave   bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  if (N < 2 || (1 << LOGN) < N || MAX_HOLD < 1) begin : g_param_chk
    $error("rr_grant_arbiter: illegal parameters");
  end

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [LOGN-1:0] idx_q, idx_d;
  logic [LOGN-1:0] ptr_q, ptr_d;
  logic            timeout_q, timeout_d;
  logic [LOGN-1:0] pick_idx;
  logic            pick_found;
  logic            release_now;
  logic            revoke;

`ifdef RR_WATCHDOG_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  // First set request at or after ptr, wrapping past N-1 back to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && bus.req[(int'(ptr_q) + k) % N]) begin
        pick_found = 1'b1;
        pick_idx   = LOGN'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    timeout_d   = 1'b0;
    release_now = 1'b0;
    revoke      = 1'b0;
`ifdef RR_WATCHDOG_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idx_d             = pick_idx;
          state_d           = BUSY;
`ifdef RR_WATCHDOG_EN
          hold_d            = '0;
`endif
        end
      end
      BUSY: begin
        release_now = bus.done || !bus.req[idx_q];
`ifdef RR_WATCHDOG_EN
        // A normal release on the limit cycle wins, so timeout stays low.
        revoke = !release_now && (hold_q == HW'(MAX_HOLD - 1));
        hold_d = hold_q + 1'b1;
`endif
        if (release_now || revoke) begin
          grant_d   = '0;
          idx_d     = '0;
          ptr_d     = (idx_q == LOGN'(N - 1)) ? '0 : idx_q + 1'b1;
          state_d   = IDLE;
          timeout_d = revoke;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef RR_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
  logic unused_ok;
  assign unused_ok = timeout_q ^ revoke;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = |grant_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Randomized + directed bench for rr_grant_arbiter (N=4, MAX_HOLD=3) against an owner/pointer model.
module tb_rr_grant_arbiter;
  localparam int N = 4;
  localparam int LOGN = 2;
  localparam int MAX_HOLD = 3;
`ifdef RR_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  rr_grant_arbiter_if #(.N(N), .LOGN(LOGN)) bus ();

  rr_grant_arbiter #(.N(N), .LOGN(LOGN), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: owner is -1 when nobody holds the bus.
  int owner = -1;
  int ptr = 0;
  int held = 0;
  bit m_to = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      owner = -1; ptr = 0; held = 0; m_to = 1'b0;
    end else if (owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && bus.req[(ptr + k) % N]) owner = (ptr + k) % N;
      end
      held = 0;
    end else begin
      held = held + 1;
      if (bus.done || !bus.req[owner]) begin
        m_to = 1'b0; ptr = (owner + 1) % N; owner = -1;
      end else if (WD && held == MAX_HOLD) begin
        m_to = 1'b1; ptr = (owner + 1) % N; owner = -1;
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int eg;
    eg = (owner < 0) ? 0 : (1 << owner);
    chk("m_grant", int'(bus.grant), eg);
    chk("m_idx", int'(bus.grant_idx), (owner < 0) ? 0 : owner);
    chk("m_valid", int'(bus.grant_valid), (owner < 0) ? 0 : 1);
    chk("m_timeout", int'(bus.timeout), int'(m_to));
    chk("onehot", int'($onehot0(bus.grant)), 1);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; bus.req = 4'b1111; bus.done = 1'b0;
    // reset held with all requesting
    repeat (2) begin
      cyc();
      chk("rst_grant", int'(bus.grant), 0);
      chk("rst_idx", int'(bus.grant_idx), 0);
      chk("rst_valid", int'(bus.grant_valid), 0);
    end
    reset = 1'b0;
    // all requesting: strict rotation with an idle cycle between owners
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rot_grant", int'(bus.grant), 1 << (k % 4));
      bus.done = 1'b1;
      cyc();
      chk("rot_gap", int'(bus.grant), 0);
      bus.done = 1'b0;
    end
    // ptr=1 -> grant idx1, then ptr=2 with req 0011 wraps to idx0
    bus.req = 4'b0010;
    cyc(); chk("p1_grant", int'(bus.grant), 4'b0010);
    bus.done = 1'b1;
    cyc(); chk("p1_rel", int'(bus.grant), 0);
    bus.done = 1'b0; bus.req = 4'b0011;
    cyc(); chk("wrap_grant", int'(bus.grant), 4'b0001);
    chk("wrap_idx", int'(bus.grant_idx), 0);
    bus.done = 1'b1;
    cyc(); bus.done = 1'b0;
    cyc(); chk("ptr1_grant", int'(bus.grant), 4'b0010);
    bus.done = 1'b1;
    cyc(); bus.done = 1'b0;
    // owner drops its request
    bus.req = 4'b0100;
    cyc(); chk("own_grant", int'(bus.grant), 4'b0100);
    bus.req = 4'b1011;
    cyc(); chk("drop_rel", int'(bus.grant), 0);
    cyc(); chk("drop_next", int'(bus.grant), 4'b1000);
    chk("drop_idx", int'(bus.grant_idx), 3);
    bus.done = 1'b1;
    cyc(); bus.done = 1'b0;
    // reset mid-grant
    bus.req = 4'b0010;
    cyc(); chk("mid_grant", int'(bus.grant), 4'b0010);
    reset = 1'b1; bus.req = 4'b0110;
    cyc(); chk("mid_rst", int'(bus.grant), 0);
    chk("mid_rst_v", int'(bus.grant_valid), 0);
    reset = 1'b0;
    cyc(); chk("post_rst", int'(bus.grant), 4'b0010);
    bus.done = 1'b1;
    cyc(); bus.done = 1'b0;
    // single requester that never signals done
    bus.req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      cyc(); chk("wd_hold", int'(bus.grant), 4'b0001);
    end
    cyc();
    if (WD) begin
      chk("wd_revoke", int'(bus.grant), 0);
      chk("wd_timeout", int'(bus.timeout), 1);
      cyc(); chk("wd_regrant", int'(bus.grant), 4'b0001);
      chk("wd_to_clr", int'(bus.timeout), 0);
    end else begin
      chk("nowd_hold", int'(bus.grant), 4'b0001);
      chk("nowd_to", int'(bus.timeout), 0);
    end
    bus.req = 4'b0000;
    cyc(); chk("idle_grant", int'(bus.grant), 0);
    bus.done = 1'b1;
    cyc(); chk("idle_done", int'(bus.grant), 0);
    bus.done = 1'b0;
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      bus.req   = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      bus.done  = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1) cyc();
      else begin
        cyc();
        cyc();
      end
    end
    reset = 1'b0;
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
